// File: rtl/ila_trace_pkg.sv
// Shared types and entry layout for the commit-trace capture buffer.
package ila_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    // Fixed-width fields of one trace entry; PC and register data widths vary.
    localparam int TIME_W  = 32;
    localparam int INSTR_W = 32;
    localparam int WEN_W   = 1;
    localparam int WADDR_W = 5;

    // Entry layout, MSB first: {csr_time, pc, instr, rd_wen, rd_waddr, rd_wdata}.
    function automatic int entry_width(input int pc_w, input int xlen);
        return TIME_W + pc_w + INSTR_W + WEN_W + WADDR_W + xlen;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module trace_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on storage or read data so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ila_trace_buffer.sv
// Retirement trace buffer: circular capture, PC-match trigger with post window,
// oldest-first drain of the frozen window over a valid/ready stream.
module ila_trace_buffer
    import ila_trace_pkg::*;
#(
    parameter int DEPTH     = 512,
    parameter int POST_TRIG = 256,
    parameter int PC_W      = 40,
    parameter int XLEN      = 64
) (
    input  logic                            coreclk,
    input  logic                            corerst,
    input  logic                            ila_instr_valid,
    input  logic [PC_W-1:0]                 ila_pc,
    input  logic [31:0]                     ila_instr,
    input  logic                            ila_rd_wen,
    input  logic [4:0]                      ila_rd_waddr,
    input  logic [XLEN-1:0]                 ila_rd_wdata,
    input  logic [31:0]                     ila_csr_time,
    input  logic                            arm,
    input  logic                            clear,
    input  logic                            trig_en,
    input  logic [PC_W-1:0]                 trig_pc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PC_W+32+1+5+XLEN+32-1:0]  out_data,
    output logic                            out_last,
    output logic [1:0]                      state,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_width(PC_W, XLEN);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] POST_INIT = CW'(POST_TRIG);
    localparam logic [CW-1:0] ONE       = CW'(1);

    // Stream handshake: a beat transfers on a cycle where out_valid and
    // out_ready are both high; while out_valid is high and out_ready is low,
    // out_valid, out_data and out_last hold their values.

    trace_state_t   st;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  rd_left;
    logic [CW-1:0]  post_cnt;
    logic           ram_v;
    logic           ram_last;
    logic [EW-1:0]  ram_q;

    logic [EW-1:0]  entry;
    logic           capture;
    logic           hit;
    logic           enter_done;
    logic           beat;
    logic           load_out;
    logic           issue;
    logic [AW-1:0]  wr_ptr_nx;
    logic [CW-1:0]  cnt_nx;
    logic [AW-1:0]  rd_start;

    assign entry     = {ila_csr_time, ila_pc, ila_instr, ila_rd_wen, ila_rd_waddr, ila_rd_wdata};
    assign capture   = ila_instr_valid && !clear && (st == ST_ARMED || st == ST_POST);
    assign hit       = !trig_en || (ila_pc == trig_pc);
    assign wr_ptr_nx = wr_ptr + 1'b1;
    assign cnt_nx    = (cnt == FULL) ? cnt : cnt + 1'b1;
    assign rd_start  = wr_ptr_nx - cnt_nx[AW-1:0];
    assign enter_done = capture &&
                        ((st == ST_ARMED && hit && POST_INIT == '0) ||
                         (st == ST_POST && post_cnt == ONE));

    // Two-stage read pipe (RAM data register, output register) keeps one
    // beat per cycle while the consumer is ready and stalls cleanly otherwise.
    assign beat     = out_valid && out_ready;
    assign load_out = ram_v && (!out_valid || out_ready);
    assign issue    = (st == ST_DONE) && (rd_left != '0) && (!ram_v || load_out);

    assign state = st;
    assign count = cnt;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (coreclk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata (entry),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge coreclk) begin
        if (corerst) begin
            st        <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            rd_left   <= '0;
            post_cnt  <= '0;
            ram_v     <= 1'b0;
            ram_last  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            rd_left   <= '0;
            ram_v     <= 1'b0;
            ram_last  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (arm) begin
                        st     <= ST_ARMED;
                        wr_ptr <= '0;
                        cnt    <= '0;
                    end
                end
                ST_ARMED: begin
                    if (capture) begin
                        wr_ptr <= wr_ptr_nx;
                        cnt    <= cnt_nx;
                        if (hit) begin
                            st       <= (POST_INIT == '0) ? ST_DONE : ST_POST;
                            post_cnt <= POST_INIT;
                        end
                    end
                end
                ST_POST: begin
                    if (capture) begin
                        wr_ptr   <= wr_ptr_nx;
                        cnt      <= cnt_nx;
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ONE) begin
                            st <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (beat) begin
                        cnt <= cnt - 1'b1;
                        if (out_last) begin
                            st  <= ST_IDLE;
                            cnt <= '0;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase

            // The frozen window starts count entries behind the final write.
            if (enter_done) begin
                rd_ptr  <= rd_start;
                rd_left <= cnt_nx;
            end
            if (issue) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rd_left  <= rd_left - 1'b1;
                ram_last <= (rd_left == ONE);
            end

            if (issue) begin
                ram_v <= 1'b1;
            end else if (load_out) begin
                ram_v <= 1'b0;
            end

            if (load_out) begin
                out_valid <= 1'b1;
                out_data  <= ram_q;
                out_last  <= ram_last;
            end else if (beat) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ila_trace_buffer.sv
// Self-checking bench for ila_trace_buffer against a queue-based trace model.
module tb_ila_trace_buffer;

    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 2;
    localparam int PC_W      = 40;
    localparam int XLEN      = 64;
    localparam int EW        = PC_W + 32 + 1 + 5 + XLEN + 32;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            corerst;
    logic            ila_instr_valid;
    logic [PC_W-1:0] ila_pc;
    logic [31:0]     ila_instr;
    logic            ila_rd_wen;
    logic [4:0]      ila_rd_waddr;
    logic [XLEN-1:0] ila_rd_wdata;
    logic [31:0]     ila_csr_time;
    logic            arm, arm0, clear, trig_en;
    logic [PC_W-1:0] trig_pc;
    logic            out_valid, out_ready, out_last;
    logic [EW-1:0]   out_data;
    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic            out_valid0, out_ready0, out_last0;
    logic [EW-1:0]   out_data0;
    logic [1:0]      state0;
    logic [CW-1:0]   count0;

    int errors = 0;
    int checks = 0;

    // Model: captured window (oldest at index 0) and phase 0..3 as numbered at the interface.
    logic [EW-1:0] exp_q[$];
    int m_state = 0;
    int m_post  = 0;

    always #5 clk = ~clk;

    ila_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .PC_W(PC_W), .XLEN(XLEN)) u_dut (
        .coreclk(clk), .corerst(corerst), .ila_instr_valid(ila_instr_valid), .ila_pc(ila_pc),
        .ila_instr(ila_instr), .ila_rd_wen(ila_rd_wen), .ila_rd_waddr(ila_rd_waddr),
        .ila_rd_wdata(ila_rd_wdata), .ila_csr_time(ila_csr_time), .arm(arm), .clear(clear),
        .trig_en(trig_en), .trig_pc(trig_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .state(state), .count(count)
    );

    ila_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(0), .PC_W(PC_W), .XLEN(XLEN)) u_dut0 (
        .coreclk(clk), .corerst(corerst), .ila_instr_valid(ila_instr_valid), .ila_pc(ila_pc),
        .ila_instr(ila_instr), .ila_rd_wen(ila_rd_wen), .ila_rd_waddr(ila_rd_waddr),
        .ila_rd_wdata(ila_rd_wdata), .ila_csr_time(ila_csr_time), .arm(arm0), .clear(clear),
        .trig_en(trig_en), .trig_pc(trig_pc), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .out_last(out_last0), .state(state0), .count(count0)
    );

    function automatic logic [PC_W-1:0] rand_pc();
        logic [PC_W-1:0] p;
        p = PC_W'({$urandom, $urandom});
        p[0] = 1'b1;
        return p;
    endfunction

    function automatic void model_capture(input logic [EW-1:0] e, input logic [PC_W-1:0] pc);
        if (m_state == 1 || m_state == 2) begin
            exp_q.push_back(e);
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            if (m_state == 1) begin
                if (!trig_en || pc == trig_pc) begin
                    m_post  = POST_TRIG;
                    m_state = (POST_TRIG == 0) ? 3 : 2;
                end
            end else begin
                m_post = m_post - 1;
                if (m_post == 0) m_state = 3;
            end
        end
    endfunction

    task automatic drive_fields(input logic [PC_W-1:0] pc, output logic [EW-1:0] e);
        ila_pc          = pc;
        ila_instr       = $urandom;
        ila_rd_wen      = 1'($urandom_range(0, 1));
        ila_rd_waddr    = 5'($urandom_range(0, 31));
        ila_rd_wdata    = {$urandom, $urandom};
        ila_csr_time    = $urandom;
        ila_instr_valid = 1'b1;
        e = {ila_csr_time, ila_pc, ila_instr, ila_rd_wen, ila_rd_waddr, ila_rd_wdata};
    endtask

    task automatic retire(input logic [PC_W-1:0] pc);
        logic [EW-1:0] e;
        @(negedge clk);
        drive_fields(pc, e);
        model_capture(e, pc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ila_instr_valid = 1'b0;
            arm = 1'b0;
            arm0 = 1'b0;
            clear = 1'b0;
        end
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        ila_instr_valid = 1'b0;
        arm = 1'b1;
        if (m_state == 0) begin
            m_state = 1;
            exp_q.delete();
        end
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        ila_instr_valid = 1'b0;
        clear = 1'b1;
        m_state = 0;
        exp_q.delete();
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Drains up to max_beats entries; mode 0 ready always, 1 pattern 1,0,0,1, 2 random.
    task automatic drain(input int mode, input int max_beats, input bit lat_chk);
        int  beats = 0;
        int  cyc = 0;
        bit  seen = 1'b0;
        bit  rdy;
        while (exp_q.size() > 0 && beats < max_beats && cyc < 300) begin
            @(negedge clk);
            ila_instr_valid = 1'b0;
            cyc++;
            if (lat_chk && !seen && out_valid) begin
                checks++;
                if (cyc != 2) begin
                    errors++;
                    $display("FAIL first_beat_latency: got %0d cycles after DONE+1, expected 2", cyc);
                end
            end
            if (out_valid) seen = 1'b1;
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (out_valid) begin
                checks++;
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL drain_data: got %h expected %h", out_data, exp_q[0]);
                end
                if (rdy) begin
                    void'(exp_q.pop_front());
                    beats++;
                    checks++;
                    if (out_last !== (exp_q.size() == 0)) begin
                        errors++;
                        $display("FAIL drain_last: got %b expected %b", out_last, exp_q.size() == 0);
                    end
                end
            end
        end
        if (exp_q.size() > 0 && beats < max_beats) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats, %0d entries still expected", beats, exp_q.size());
        end
        if (exp_q.size() == 0) m_state = 0;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        corerst = 1'b1;
        idle(3);
        corerst = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || count !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_values: got state=%0d count=%0d valid=%b last=%b data=%h expected all zero",
                     state, count, out_valid, out_last, out_data);
        end
    endtask

    task automatic test_basic();
        trig_en = 1'b1;
        trig_pc = 40'h80000010;
        pulse_arm();
        for (int k = 0; k < 10; k++) retire(40'h80000000 + 4 * k);
        idle(1);
        checks++;
        if (state !== 2'(m_state) || count !== CW'(exp_q.size())) begin
            errors++;
            $display("FAIL basic_done: got state=%0d count=%0d expected state=%0d count=%0d",
                     state, count, m_state, exp_q.size());
        end
        drain(0, 100, 1'b0);
        checks++;
        if (state !== 2'd0 || count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_drain: got state=%0d count=%0d valid=%b expected 0 0 0",
                     state, count, out_valid);
        end
    endtask

    task automatic test_wrap_stall();
        trig_en = 1'b1;
        trig_pc = 40'h80000010;
        pulse_arm();
        for (int k = 0; k < 20; k++) retire(40'h90000000 + 4 * k);
        retire(trig_pc);
        retire(rand_pc());
        retire(rand_pc());
        idle(1);
        checks++;
        if (count !== CW'(8) || state !== 2'd3) begin
            errors++;
            $display("FAIL wrap_count: got count=%0d state=%0d expected count=8 state=3", count, state);
        end
        drain(1, 100, 1'b0);
        checks++;
        if (state !== 2'd0 || count !== '0) begin
            errors++;
            $display("FAIL wrap_after_drain: got state=%0d count=%0d expected 0 0", state, count);
        end
    endtask

    task automatic test_single();
        logic [EW-1:0] e;
        trig_en = 1'b0;
        @(negedge clk);
        arm0 = 1'b1;
        @(negedge clk);
        arm0 = 1'b0;
        @(negedge clk);
        drive_fields(rand_pc(), e);
        @(negedge clk);
        ila_instr_valid = 1'b0;
        checks++;
        if (state0 !== 2'd3 || count0 !== CW'(1) || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got state=%0d count=%0d valid=%b expected 3 1 0",
                     state0, count0, out_valid0);
        end
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: got %b expected 0", out_valid0);
        end
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== e || out_last0 !== 1'b1) begin
            errors++;
            $display("FAIL single_beat: got valid=%b last=%b data=%h expected 1 1 %h",
                     out_valid0, out_last0, out_data0, e);
        end
        out_ready0 = 1'b1;
        @(negedge clk);
        out_ready0 = 1'b0;
        checks++;
        if (state0 !== 2'd0 || count0 !== '0 || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got state=%0d count=%0d valid=%b expected 0 0 0",
                     state0, count0, out_valid0);
        end
    endtask

    task automatic test_back_to_back();
        int npre;
        trig_pc = 40'h80000010;
        for (int it = 0; it < 3; it++) begin
            trig_en = (it != 1);
            npre = trig_en ? $urandom_range(0, 12) : 0;
            pulse_arm();
            for (int k = 0; k < npre; k++) retire(rand_pc());
            retire(trig_pc);
            retire(rand_pc());
            retire(rand_pc());
            idle(1);
            checks++;
            if (state !== 2'(m_state) || count !== CW'(exp_q.size()) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_done: got state=%0d count=%0d valid=%b expected %0d %0d 0",
                         state, count, out_valid, m_state, exp_q.size());
            end
            drain(2, 100, 1'b1);
            checks++;
            if (state !== 2'd0 || count !== '0) begin
                errors++;
                $display("FAIL b2b_after_drain: got state=%0d count=%0d expected 0 0", state, count);
            end
        end
    endtask

    task automatic test_clear();
        logic [EW-1:0] e;
        trig_en = 1'b1;
        trig_pc = 40'h80000010;
        pulse_arm();
        retire(trig_pc);
        pulse_clear();
        checks++;
        if (state !== 2'd0 || count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_post: got state=%0d count=%0d valid=%b expected 0 0 0", state, count, out_valid);
        end
        @(negedge clk);
        arm = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        clear = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL clear_beats_arm: got state=%0d expected 0", state);
        end
        pulse_arm();
        @(negedge clk);
        drive_fields(trig_pc, e);
        clear = 1'b1;
        m_state = 0;
        exp_q.delete();
        idle(1);
        checks++;
        if (state !== 2'd0 || count !== '0) begin
            errors++;
            $display("FAIL clear_beats_trigger: got state=%0d count=%0d expected 0 0", state, count);
        end
        pulse_arm();
        retire(trig_pc);
        retire(rand_pc());
        retire(rand_pc());
        idle(3);
        pulse_arm();
        checks++;
        if (state !== 2'd3 || count !== CW'(exp_q.size())) begin
            errors++;
            $display("FAIL arm_in_done: got state=%0d count=%0d expected 3 %0d", state, count, exp_q.size());
        end
        drain(0, 1, 1'b0);
        checks++;
        if (count !== CW'(exp_q.size())) begin
            errors++;
            $display("FAIL count_decrement: got %0d expected %0d", count, exp_q.size());
        end
        pulse_clear();
        checks++;
        if (state !== 2'd0 || count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_drain: got state=%0d count=%0d valid=%b expected 0 0 0", state, count, out_valid);
        end
    endtask

    task automatic test_reset_post();
        trig_en = 1'b1;
        trig_pc = 40'h80000010;
        pulse_arm();
        retire(trig_pc);
        retire(rand_pc());
        @(negedge clk);
        ila_instr_valid = 1'b0;
        corerst = 1'b1;
        @(negedge clk);
        corerst = 1'b0;
        m_state = 0;
        exp_q.delete();
        checks++;
        if (state !== 2'd0 || count !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_in_post: got state=%0d count=%0d valid=%b last=%b data=%h expected all zero",
                     state, count, out_valid, out_last, out_data);
        end
        pulse_arm();
        retire(trig_pc);
        retire(rand_pc());
        retire(rand_pc());
        idle(1);
        checks++;
        if (state !== 2'd3 || count !== CW'(3)) begin
            errors++;
            $display("FAIL rearm_after_reset: got state=%0d count=%0d expected 3 3", state, count);
        end
        drain(0, 100, 1'b1);
        checks++;
        if (state !== 2'd0 || count !== '0) begin
            errors++;
            $display("FAIL rearm_drain: got state=%0d count=%0d expected 0 0", state, count);
        end
    endtask

    initial begin
        corerst = 1'b1;
        ila_instr_valid = 1'b0;
        ila_pc = '0;
        ila_instr = '0;
        ila_rd_wen = 1'b0;
        ila_rd_waddr = '0;
        ila_rd_wdata = '0;
        ila_csr_time = '0;
        arm = 1'b0;
        arm0 = 1'b0;
        clear = 1'b0;
        trig_en = 1'b1;
        trig_pc = '0;
        out_ready = 1'b0;
        out_ready0 = 1'b0;

        test_reset();
        test_basic();
        test_wrap_stall();
        test_single();
        test_back_to_back();
        test_clear();
        test_reset_post();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
